// File: rtl/vtc_timing_gen.sv
// Video timing generator: HS/VS/DE, pixel coordinates and frame/line strobes
// from a single pixel clock. Timing is reprogrammable through a valid/ready
// shadow register and only takes effect at a frame boundary. A second
// counter pair runs LEAD pixels ahead to produce an early pixel request.
module vtc_timing_gen #(
  parameter int H_W      = 12,
  parameter int V_W      = 11,
  parameter int H_ACTIVE = 1920,
  parameter int H_SYNC_S = 2008,
  parameter int H_SYNC_E = 2052,
  parameter int H_FRAME  = 2200,
  parameter int V_ACTIVE = 1080,
  parameter int V_SYNC_S = 1084,
  parameter int V_SYNC_E = 1089,
  parameter int V_FRAME  = 1125,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int LEAD     = 2
) (
  input  logic             Pixl_CLK,
  input  logic             Rst_Posedge,
  input  logic             I_Cfg_Valid,
  output logic             O_Cfg_Ready,
  input  logic [4*H_W-1:0] I_Cfg_H,
  input  logic [4*V_W-1:0] I_Cfg_V,
  output logic             O_Hs,
  output logic             O_Vs,
  output logic             O_De,
  output logic             O_Pixel_Req,
  output logic [H_W-1:0]   O_X,
  output logic [V_W-1:0]   O_Y,
  output logic             O_Frame_Start,
  output logic             O_Line_Start
);

  // Field index inside a packed timing word: {frame, sync_e, sync_s, active}
  localparam int F_ACT = 0;
  localparam int F_SS  = 1;
  localparam int F_SE  = 2;
  localparam int F_FR  = 3;

  localparam logic [4*H_W-1:0] H_DEFAULT =
    {H_W'(H_FRAME), H_W'(H_SYNC_E), H_W'(H_SYNC_S), H_W'(H_ACTIVE)};
  localparam logic [4*V_W-1:0] V_DEFAULT =
    {V_W'(V_FRAME), V_W'(V_SYNC_E), V_W'(V_SYNC_S), V_W'(V_ACTIVE)};

  localparam logic [H_W-1:0] H_ONE  = H_W'(1);
  localparam logic [V_W-1:0] V_ONE  = V_W'(1);
  // Lead pair start position; LEAD is always shorter than one line
  localparam logic [H_W-1:0] LEAD_H = H_W'(LEAD);
  localparam logic           HS_ON  = (HS_POL != 0);
  localparam logic           VS_ON  = (VS_POL != 0);

  logic [4*H_W-1:0] h_tim_reg, h_shd_reg;
  logic [4*V_W-1:0] v_tim_reg, v_shd_reg;
  logic             pending_reg;

  logic [H_W-1:0]   h_fld [4];
  logic [V_W-1:0]   v_fld [4];

  logic [H_W-1:0]   h_reg, h_next, lh_reg, lh_next;
  logic [V_W-1:0]   v_reg, v_next, lv_reg, lv_next;

  logic h_last, v_last, lh_last, lv_last;
  logic apply, xfer;
  logic de_c, req_c, hs_c, vs_c;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fld
      assign h_fld[gi] = h_tim_reg[gi*H_W +: H_W];
      assign v_fld[gi] = v_tim_reg[gi*V_W +: V_W];
    end
  endgenerate

  // The shadow register is free whenever nothing is waiting for a frame end
  assign O_Cfg_Ready = ~pending_reg;
  assign xfer        = I_Cfg_Valid & ~pending_reg;

  assign h_last  = (h_reg  == h_fld[F_FR] - H_ONE);
  assign v_last  = (v_reg  == v_fld[F_FR] - V_ONE);
  assign lh_last = (lh_reg == h_fld[F_FR] - H_ONE);
  assign lv_last = (lv_reg == v_fld[F_FR] - V_ONE);
  assign apply   = h_last & v_last & pending_reg;

  // Active/shadow timing and the pending flag; apply only at the last pixel
  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) begin
      h_tim_reg   <= H_DEFAULT;
      v_tim_reg   <= V_DEFAULT;
      h_shd_reg   <= H_DEFAULT;
      v_shd_reg   <= V_DEFAULT;
      pending_reg <= 1'b0;
    end else if (xfer) begin
      h_shd_reg   <= I_Cfg_H;
      v_shd_reg   <= I_Cfg_V;
      pending_reg <= 1'b1;
    end else if (apply) begin
      h_tim_reg   <= h_shd_reg;
      v_tim_reg   <= v_shd_reg;
      pending_reg <= 1'b0;
    end
  end

  // Next position of the main and lead counter pairs
  always_comb begin
    h_next  = h_reg + H_ONE;
    v_next  = v_reg;
    lh_next = lh_reg + H_ONE;
    lv_next = lv_reg;
    if (h_last) begin
      h_next = '0;
      v_next = v_last ? '0 : v_reg + V_ONE;
    end
    if (lh_last) begin
      lh_next = '0;
      lv_next = lv_last ? '0 : lv_reg + V_ONE;
    end
    // A new timing restarts both pairs, even if it matches the old one
    if (apply) begin
      h_next  = '0;
      v_next  = '0;
      lh_next = LEAD_H;
      lv_next = '0;
    end
  end

  // Counter state registers
  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) begin
      h_reg  <= '0;
      v_reg  <= '0;
      lh_reg <= LEAD_H;
      lv_reg <= '0;
    end else begin
      h_reg  <= h_next;
      v_reg  <= v_next;
      lh_reg <= lh_next;
      lv_reg <= lv_next;
    end
  end

  // Decode of the current counter positions against the active timing
  always_comb begin
    de_c  = (h_reg < h_fld[F_ACT]) && (v_reg < v_fld[F_ACT]);
    req_c = (lh_reg < h_fld[F_ACT]) && (lv_reg < v_fld[F_ACT]);
    hs_c  = (h_reg >= h_fld[F_SS]) && (h_reg < h_fld[F_SE]);
    vs_c  = (v_reg >= v_fld[F_SS]) && (v_reg < v_fld[F_SE]);
  end

  // Output registers: one cycle behind the counters
  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) begin
      O_Hs          <= ~HS_ON;
      O_Vs          <= ~VS_ON;
      O_De          <= 1'b0;
      O_Pixel_Req   <= 1'b0;
      O_X           <= '0;
      O_Y           <= '0;
      O_Frame_Start <= 1'b0;
      O_Line_Start  <= 1'b0;
    end else begin
      O_Hs          <= hs_c ? HS_ON : ~HS_ON;
      O_Vs          <= vs_c ? VS_ON : ~VS_ON;
      O_De          <= de_c;
      O_Pixel_Req   <= req_c;
      O_X           <= h_reg;
      O_Y           <= v_reg;
      O_Frame_Start <= (h_reg == '0) && (v_reg == '0);
      O_Line_Start  <= (h_reg == '0);
    end
  end

endmodule

// File: tb/tb_vtc_timing_gen.sv
// Randomized bench for vtc_timing_gen. Two instances share the stimulus:
// inst a (LEAD=2, active-high syncs) and inst b (LEAD=0, active-low syncs).
// The reference model tracks the frame as a linear pixel index and derives
// every output from it with plain arithmetic.
module tb_vtc_timing_gen;

  localparam int H_W = 12;
  localparam int V_W = 11;
  // Reduced default timing so whole frames fit in a short run
  localparam int DHA = 24, DHS = 28, DHE = 32, DHF = 36;
  localparam int DVA = 10, DVS = 12, DVE = 14, DVF = 16;
  localparam int LEAD_A = 2;
  localparam int LEAD_B = 0;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [4*H_W-1:0] cfg_h;
  logic [4*V_W-1:0] cfg_v;

  logic a_ready, a_hs, a_vs, a_de, a_req, a_fs, a_ls;
  logic b_ready, b_hs, b_vs, b_de, b_req, b_fs, b_ls;
  logic [H_W-1:0] a_x, b_x;
  logic [V_W-1:0] a_y, b_y;
  logic [31:0] a_vec, b_vec;

  assign a_vec = {2'b00, a_ready, a_hs, a_vs, a_de, a_req, a_fs, a_ls, a_x, a_y};
  assign b_vec = {2'b00, b_ready, b_hs, b_vs, b_de, b_req, b_fs, b_ls, b_x, b_y};

  vtc_timing_gen #(
    .H_W(H_W), .V_W(V_W),
    .H_ACTIVE(DHA), .H_SYNC_S(DHS), .H_SYNC_E(DHE), .H_FRAME(DHF),
    .V_ACTIVE(DVA), .V_SYNC_S(DVS), .V_SYNC_E(DVE), .V_FRAME(DVF),
    .HS_POL(1), .VS_POL(1), .LEAD(LEAD_A)
  ) u_a (
    .Pixl_CLK(clk), .Rst_Posedge(rst), .I_Cfg_Valid(cfg_valid),
    .O_Cfg_Ready(a_ready), .I_Cfg_H(cfg_h), .I_Cfg_V(cfg_v),
    .O_Hs(a_hs), .O_Vs(a_vs), .O_De(a_de), .O_Pixel_Req(a_req),
    .O_X(a_x), .O_Y(a_y), .O_Frame_Start(a_fs), .O_Line_Start(a_ls)
  );

  vtc_timing_gen #(
    .H_W(H_W), .V_W(V_W),
    .H_ACTIVE(DHA), .H_SYNC_S(DHS), .H_SYNC_E(DHE), .H_FRAME(DHF),
    .V_ACTIVE(DVA), .V_SYNC_S(DVS), .V_SYNC_E(DVE), .V_FRAME(DVF),
    .HS_POL(0), .VS_POL(0), .LEAD(LEAD_B)
  ) u_b (
    .Pixl_CLK(clk), .Rst_Posedge(rst), .I_Cfg_Valid(cfg_valid),
    .O_Cfg_Ready(b_ready), .I_Cfg_H(cfg_h), .I_Cfg_V(cfg_v),
    .O_Hs(b_hs), .O_Vs(b_vs), .O_De(b_de), .O_Pixel_Req(b_req),
    .O_X(b_x), .O_Y(b_y), .O_Frame_Start(b_fs), .O_Line_Start(b_ls)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: timing fields {ha,hss,hse,hf,va,vss,vse,vf}, shadow, index
  int m_t [8];
  int m_s [8];
  bit m_pend;
  int m_p;
  bit m_xfer;

  bit acc_en;
  int acc_de, acc_hs, acc_vs, acc_req, acc_fs, acc_hs_b, acc_vs_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void set_defaults();
    m_t = '{DHA, DHS, DHE, DHF, DVA, DVS, DVE, DVF};
    m_s = '{DHA, DHS, DHE, DHF, DVA, DVS, DVE, DVF};
  endfunction

  // Expected output word for the pixel at index m_p under the active timing
  function automatic logic [31:0] pos_vec(input int lead, input bit hpol, input bit vpol);
    int hf, vf, h, v, q, lh, lv;
    logic hs_raw, vs_raw, de, req, fs, ls;
    hf = m_t[3];
    vf = m_t[7];
    h  = m_p % hf;
    v  = m_p / hf;
    q  = (m_p + lead) % (hf * vf);
    lh = q % hf;
    lv = q / hf;
    de     = (h < m_t[0]) && (v < m_t[4]);
    req    = (lh < m_t[0]) && (lv < m_t[4]);
    hs_raw = (h >= m_t[1]) && (h < m_t[2]);
    vs_raw = (v >= m_t[5]) && (v < m_t[6]);
    fs     = (h == 0) && (v == 0);
    ls     = (h == 0);
    return {2'b00, 1'b0, (hs_raw ? hpol : !hpol), (vs_raw ? vpol : !vpol),
            de, req, fs, ls, 12'(h), 11'(v)};
  endfunction

  function automatic logic [31:0] reset_vec(input bit hpol, input bit vpol);
    return {2'b00, 1'b1, !hpol, !vpol, 4'b0000, 23'd0};
  endfunction

  // One clock: predict, advance the model, then compare both instances
  task automatic step();
    logic [31:0] ea, eb;
    int frame;
    bit apply, xfer;
    m_xfer = 1'b0;
    if (rst) begin
      ea = reset_vec(1'b1, 1'b1);
      eb = reset_vec(1'b0, 1'b0);
      set_defaults();
      m_pend = 1'b0;
      m_p    = 0;
    end else begin
      ea    = pos_vec(LEAD_A, 1'b1, 1'b1);
      eb    = pos_vec(LEAD_B, 1'b0, 1'b0);
      frame = m_t[3] * m_t[7];
      xfer  = cfg_valid && !m_pend;
      apply = m_pend && (m_p == frame - 1);
      if (apply) begin
        m_t    = m_s;
        m_pend = 1'b0;
        m_p    = 0;
      end else begin
        m_p = (m_p + 1) % frame;
      end
      if (xfer) begin
        for (int i = 0; i < 4; i++) begin
          m_s[i]   = int'(cfg_h[i*H_W +: H_W]);
          m_s[4+i] = int'(cfg_v[i*V_W +: V_W]);
        end
        m_pend = 1'b1;
        m_xfer = 1'b1;
      end
      ea[29] = !m_pend;
      eb[29] = !m_pend;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("inst_a", a_vec, ea);
    chk("inst_b", b_vec, eb);
    if (acc_en) begin
      acc_de   += int'(a_de);
      acc_hs   += int'(a_hs);
      acc_vs   += int'(a_vs);
      acc_req  += int'(a_req);
      acc_fs   += int'(a_fs);
      acc_hs_b += int'(!b_hs);
      acc_vs_b += int'(!b_vs);
    end
    @(negedge clk);
  endtask

  task automatic set_cfg(input int ha, hs, he, hf, va, vs, ve, vf);
    cfg_h = {12'(hf), 12'(he), 12'(hs), 12'(ha)};
    cfg_v = {11'(vf), 11'(ve), 11'(vs), 11'(va)};
  endtask

  task automatic rand_cfg();
    int ha, hs, he, hf, va, vs, ve, vf;
    ha = int'($urandom_range(3, 20));
    hs = ha + int'($urandom_range(1, 4));
    he = hs + int'($urandom_range(0, 4));
    hf = he + int'($urandom_range(0, 4));
    va = int'($urandom_range(1, 10));
    vs = va + int'($urandom_range(1, 3));
    ve = vs + int'($urandom_range(0, 3));
    vf = ve + int'($urandom_range(0, 3));
    set_cfg(ha, hs, he, hf, va, vs, ve, vf);
  endtask

  // Raise valid and hold it until the model records a transfer
  task automatic offer(input bit keep_valid);
    int budget;
    budget    = 0;
    cfg_valid = 1'b1;
    do begin
      step();
      budget++;
    end while (!m_xfer && budget < 5000);
    chk("accept", 32'(m_xfer), 32'(1));
    if (!keep_valid) cfg_valid = 1'b0;
  endtask

  task automatic wait_applied();
    int budget;
    budget = 0;
    while (m_pend && budget < 5000) begin
      step();
      budget++;
    end
    chk("apply_wait", 32'(m_pend), 32'(0));
  endtask

  // Align to a frame start, then count output activity over one frame
  task automatic measure_frame(input int exp_de, input int exp_hs, input int exp_vs,
                               input int len);
    int budget;
    budget = 0;
    while (m_p != 0 && budget < 5000) begin
      step();
      budget++;
    end
    chk("align", 32'(m_p), 32'(0));
    acc_de = 0; acc_hs = 0; acc_vs = 0; acc_req = 0;
    acc_fs = 0; acc_hs_b = 0; acc_vs_b = 0;
    acc_en = 1'b1;
    repeat (len) step();
    acc_en = 1'b0;
    chk("frm_de",    32'(acc_de),   32'(exp_de));
    chk("frm_req",   32'(acc_req),  32'(exp_de));
    chk("frm_hs",    32'(acc_hs),   32'(exp_hs));
    chk("frm_vs",    32'(acc_vs),   32'(exp_vs));
    chk("frm_hs_lo", 32'(acc_hs_b), 32'(exp_hs));
    chk("frm_vs_lo", 32'(acc_vs_b), 32'(exp_vs));
    chk("frm_fs",    32'(acc_fs),   32'(1));
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_h     = '0;
    cfg_v     = '0;
    acc_en    = 1'b0;
    set_defaults();
    m_pend = 1'b0;
    m_p    = 0;
    @(negedge clk);

    // Reset defaults: 5 reset cycles, then default frames
    repeat (5) step();
    rst = 1'b0;
    measure_frame(DHA * DVA, (DHE - DHS) * DVF, DHF * (DVE - DVS), DHF * DVF);
    measure_frame(DHA * DVA, (DHE - DHS) * DVF, DHF * (DVE - DVS), DHF * DVF);

    // Small timing offered mid-frame; ready stays low until the frame ends
    repeat (200) step();
    set_cfg(8, 10, 12, 16, 4, 5, 6, 8);
    offer(1'b0);
    wait_applied();
    measure_frame(32, 16, 16, 128);
    measure_frame(32, 16, 16, 128);

    // Back-pressure: second config held on valid while the first is pending
    for (int k = 0; k < 6; k++) begin
      rand_cfg();
      offer(1'b1);
      rand_cfg();
      offer(1'b0);
      wait_applied();
      repeat ($urandom_range(0, 300)) step();
    end

    // Reset at X=5,Y=2 of the small timing with a config pending
    set_cfg(8, 10, 12, 16, 4, 5, 6, 8);
    offer(1'b0);
    wait_applied();
    measure_frame(32, 16, 16, 128);
    rand_cfg();
    offer(1'b0);
    begin
      int budget;
      budget = 0;
      while (m_p != 2 * 16 + 5 && budget < 5000) begin
        step();
        budget++;
      end
    end
    chk("pos_5_2", 32'(m_p), 32'(2 * 16 + 5));
    chk("pend_at_rst", 32'(m_pend), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    measure_frame(DHA * DVA, (DHE - DHS) * DVF, DHF * (DVE - DVS), DHF * DVF);

    // Random mix of idle time, config offers and short resets
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 200)) step();
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        rand_cfg();
        offer(1'b0);
      end
    end
    wait_applied();
    repeat (100) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
